sec_encoder_location_52bits_clk: RTL and testbench

// Clocked SEC encoder, write side of the 52-bit location-code link: takes 52-bit data,

---
 rtl/sec_location_pkg.sv | 34 +++
 rtl/sec_column_rom.sv | 25 ++
 rtl/sec_encoder_location_52bits_clk.sv | 92 +++++++++
 tb/tb_sec_encoder_location_52bits_clk.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sec_location_pkg.sv
// Shared definitions for the 52-bit location-code SEC encoder/decoder pair.
// Both sides derive their parity-check columns from sec_col() so the tables never diverge.
package sec_location_pkg;

  localparam int D_BITS   = 52;
  localparam int W_BITS   = 61;
  localparam int P_BITS   = W_BITS - D_BITS;
  localparam int CHUNK    = 4;
  localparam int N_CHUNKS = D_BITS / CHUNK;
  localparam int CNT_W    = $clog2(N_CHUNKS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Column for data bit i: the i-th integer >= 3 that is not a power of two.
  // Powers of two are left for the check bits themselves.
  function automatic logic [P_BITS-1:0] sec_col(input int i);
    int n;
    logic [P_BITS-1:0] r;
    n = 0;
    r = '0;
    for (int v = 3; v < (1 << P_BITS); v++) begin
      if ((v & (v - 1)) != 0) begin
        if (n == i) r = P_BITS'(v);
        n++;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sec_column_rom.sv
// Column lookup: for chunk index idx_i, returns the CHUNK parity columns of the data bits
// idx_i*CHUNK .. idx_i*CHUNK+CHUNK-1. Out-of-range indices return zero columns.
module sec_column_rom
  import sec_location_pkg::*;
(
  input  logic [CNT_W-1:0]              idx_i,
  output logic [CHUNK-1:0][P_BITS-1:0]  cols_o
);

  logic [CHUNK-1:0][P_BITS-1:0] col_tbl [N_CHUNKS];

  for (genvar c = 0; c < N_CHUNKS; c++) begin : g_chunk
    for (genvar k = 0; k < CHUNK; k++) begin : g_bit
      assign col_tbl[c][k] = sec_col(c * CHUNK + k);
    end
  end

  always_comb begin
    cols_o = '0;
    for (int c = 0; c < N_CHUNKS; c++) begin
      if (idx_i == CNT_W'(c)) cols_o = col_tbl[c];
    end
  end

endmodule

// File: rtl/sec_encoder_location_52bits_clk.sv
// Multi-cycle SEC encoder: folds CHUNK data bits per cycle into a 9-bit check accumulator,
// then presents {data, check} as a 61-bit codeword behind a valid/ready handshake.
module sec_encoder_location_52bits_clk
  import sec_location_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [D_BITS-1:0] D,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_BITS-1:0] W
);

  state_e                          state_q, state_d;
  logic [N_CHUNKS-1:0][CHUNK-1:0]  data_q, data_d;
  logic [P_BITS-1:0]               acc_q, acc_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [W_BITS-1:0]               w_q, w_d;

  logic [CHUNK-1:0][P_BITS-1:0]    cols;
  logic [CHUNK-1:0]                chunk_bits;
  logic [P_BITS-1:0]               acc_next;

  sec_column_rom u_rom (
    .idx_i  (cnt_q),
    .cols_o (cols)
  );

  always_comb begin
    chunk_bits = data_q[cnt_q];
    acc_next   = acc_q;
    for (int k = 0; k < CHUNK; k++) begin
      if (chunk_bits[k]) acc_next = acc_next ^ cols[k];
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    w_d       = w_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = D;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_next;
        cnt_d = cnt_q + 1'b1;
        // Last chunk: the codeword takes this cycle's accumulator result directly.
        if (cnt_q == CNT_W'(N_CHUNKS - 1)) begin
          w_d     = {data_q, acc_next};
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
    end
  end

  assign W = w_q;

endmodule

// File: tb/tb_sec_encoder_location_52bits_clk.sv
// Self-checking bench for the clocked 52-bit SEC encoder: directed vectors, stall/reset cases,
// and random words pushed through a reference single-error-correcting decoder model.
module tb_sec_encoder_location_52bits_clk;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [51:0] D;
  logic        out_valid;
  logic        out_ready;
  logic [60:0] W;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] h_tab [52];

  always #5 clk = ~clk;

  sec_encoder_location_52bits_clk dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D         (D),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .W         (W)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [60:0] ref_enc(input logic [51:0] d);
    logic [8:0] c;
    c = '0;
    for (int i = 0; i < 52; i++) if (d[i]) c ^= h_tab[i];
    return {d, c};
  endfunction

  function automatic logic [51:0] ref_dec(input logic [60:0] w);
    logic [8:0]  syn;
    logic [51:0] d;
    d   = w[60:9];
    syn = w[8:0];
    for (int i = 0; i < 52; i++) if (d[i]) syn ^= h_tab[i];
    if (syn != 0 && (syn & (syn - 9'd1)) != 0) begin
      for (int i = 0; i < 52; i++) if (h_tab[i] == syn) d[i] = ~d[i];
    end
    return d;
  endfunction

  task automatic accept(input logic [51:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("idle_timeout", 64'd0, 64'd1);
    in_valid = 1'b1;
    D        = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    D        = {$urandom, $urandom};
  endtask

  // Counts edges from the accept edge (inclusive) until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) chk("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(input bit rand_ready);
    int n;
    n = 0;
    while (out_valid && n < 200) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    if (out_valid) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [51:0] vec   [5];
    logic [60:0] fixed [3];
    logic [51:0] d;
    logic [60:0] w0, one, wc;
    int          lat;
    bit          seen, all_ok;

    begin
      int v;
      v = 3;
      for (int i = 0; i < 52; i++) begin
        while ((v & (v - 1)) == 0) v++;
        h_tab[i] = 9'(v);
        v++;
      end
    end

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; D = '0;
    #12;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_w", 64'(W), 64'd0);
    rst = 1'b0;

    vec[0] = 52'd0; vec[1] = 52'd1; vec[2] = 52'd16;
    vec[3] = {52{1'b1}}; vec[4] = {13{4'h5}};
    fixed[0] = 61'd0; fixed[1] = 61'd515; fixed[2] = 61'd8201;
    for (int t = 0; t < 5; t++) begin
      accept(vec[t]);
      wait_valid(lat);
      chk($sformatf("lat_%0d", t), 64'(lat), 64'd14);
      chk($sformatf("w_model_%0d", t), 64'(W), 64'(ref_enc(vec[t])));
      if (t < 3) chk($sformatf("w_const_%0d", t), 64'(W), 64'(fixed[t]));
      if (t == 3) chk("ones_check", 64'(W[8:0]), 64'(ref_enc(vec[t]) & 61'h1FF));
      drain(1'b0);
      chk($sformatf("ready_after_%0d", t), 64'(in_ready), 64'd1);
    end

    d = {$urandom, $urandom};
    accept(d);
    wait_valid(lat);
    w0 = W;
    chk("hold_w0", 64'(w0), 64'(ref_enc(d)));
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      D = {$urandom, $urandom};
      @(posedge clk);
      @(negedge clk);
      chk("hold_w", 64'(W), 64'(w0));
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", 64'(out_valid), 64'd0);
    chk("release_in_ready", 64'(in_ready), 64'd1);

    accept({$urandom, $urandom});
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_w", 64'(W), 64'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_valid", 64'(seen), 64'd0);
    d = {$urandom, $urandom};
    accept(d);
    wait_valid(lat);
    chk("post_rst_w", 64'(W), 64'(ref_enc(d)));
    drain(1'b0);

    one = 61'd1;
    for (int r = 0; r < 2000; r++) begin
      d = {$urandom, $urandom};
      accept(d);
      wait_valid(lat);
      chk("rand_w", 64'(W), 64'(ref_enc(d)));
      all_ok = 1'b1;
      for (int b = -1; b < 61; b++) begin
        wc = (b < 0) ? W : (W ^ (one << b));
        if (ref_dec(wc) !== d) all_ok = 1'b0;
      end
      chk("rand_correct", 64'(all_ok), 64'd1);
      drain(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
